membus_arbiter: RTL and testbench
=================================

Name: membus_arbiter

Overview:
- Shares one single-port synchronous memory slave between NREQ requesters using round-robin arbitration.
- Sits between requester blocks (testers, DMA, CPU-side logic) and one memory with a registered read port: 1-cycle read latency, write on the clock edge, read-before-write on the same address.
- Performs at most one memory access per cycle and returns read data to the owning requester one cycle after its grant.

Parameters:
- NREQ, 4, number of requesters (2..16).
- LEN, 256, memory depth in words; AW = $clog2(LEN).
- DW, 8, data width in bits.
- CW, 16, width of the saturating contention counter.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- req  in  NREQ  per-requester access request; requester holds it and its payload until granted.
- wr_in  in  NREQ  per-requester: 1 = write, 0 = read.
- addr_in  in  NREQ x AW  per-requester address (unpacked array [NREQ]).
- d_in  in  NREQ x DW  per-requester write data.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the access is issued.
- rvalid  out  NREQ  one-hot read-data-valid strobe.
- rdata  out  DW  read data, shared by all requesters, qualified by rvalid.
- mem_addr  out  AW  memory address.
- mem_d  out  DW  memory write data.
- mem_wr  out  1  memory write enable.
- mem_q  in  DW  memory registered read data.
- contention_cnt  out  CW  count of cycles in which more than one req was high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ptr = 0, rd_pend = 0, rd_owner = 0, contention_cnt = 0.
  - gnt, rvalid and mem_wr are forced to 0 combinationally while rst_n is low.
  - mem_addr = 0, mem_d = 0, rdata = mem_q.
- Arbitration (combinational):
  - Winner = first i with req[i]=1, scanning i = ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - No request: gnt = 0, mem_wr = 0, mem_addr = 0, mem_d = 0.
  - Otherwise: gnt[w] = 1, mem_addr = addr_in[w], mem_d = d_in[w], mem_wr = wr_in[w].
- Pointer update: on a clock edge with a grant, ptr <= (w+1) mod NREQ. Without a grant, ptr holds.
- Handshake:
  - An access completes on the edge where gnt[i] = 1.
  - The requester then either changes its payload or drops req for the next cycle.
  - A req held after a grant is a new access; it gets no priority boost.
- Read return: if a read is granted in cycle T, then at edge T rd_pend <= 1 and rd_owner <= w. In cycle T+1, rvalid[rd_owner] = 1 and rdata = mem_q.
- Back-to-back reads (same or different requesters) give one rvalid per cycle with no bubbles.
- Writes never assert rvalid.
- Write then read of the same address in consecutive cycles returns the new data. A read and a write cannot occur in the same cycle.
- Fairness:
  - With all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0,...
  - Maximum wait for any requester is NREQ-1 cycles.
- Contention counter: increments on each edge where popcount(req) >= 2, and saturates at 2^CW-1 (no wrap).
- Reset mid-operation: a pending read is discarded and no rvalid follows reset release. The first grant after release goes to the lowest-index active requester.
- Single requester active: granted every cycle; ptr cycles but this has no effect.

Decomposition:
- Package membus_arb_pkg: function aw(LEN) wrapper for $clog2, and typedef for the per-requester payload struct {wr, addr, d}, parameterised via the module.
- One sub-module, rr_pick #(NREQ): inputs req and ptr; outputs valid, one-hot gnt and binary index. Purely combinational, reused by later arbiters.
- Pointer, read-owner pipeline and counter stay in membus_arbiter.

Test Plan:
- Reset and single write/read: requester 2 writes 0xA5 to addr 0x10, then reads 0x10 next cycle. Expect gnt[2] on both cycles, rvalid[2] in the cycle after the read grant, rdata = 0xA5, rvalid[0,1,3] = 0.
- Full contention: all 4 requesters hold reads of addr = i for 8 cycles after memory was preloaded with 0x40+i. Expect gnt order 0,1,2,3,0,1,2,3; rvalid order delayed by one cycle; rdata = 0x40,0x41,...; contention_cnt = 8.
- Pointer rotation: req = 4'b1001 continuous. Expect grants alternating 0,3,0,3. Then req[1] is raised after a grant to 3; expect the next grant to go to 0, then 1.
- Read-after-write ordering: req0 writes 0x55 to addr 5 in cycle T and req1 reads addr 5 in T+1. Expect rdata = 0x55 at T+2 with rvalid[1].
- Async reset mid-read: assert rst_n low mid-cycle right after a read grant. Expect gnt, rvalid and mem_wr = 0 immediately. After release, no stray rvalid appears and the first grant goes to the lowest active index.
- Counter saturation with CW = 4: hold 2 requests for 20 cycles. Expect contention_cnt stops at 15.

Source files
------------

// File: rtl/membus_arb_pkg.sv
// membus_arb_pkg: shared helpers for the memory bus arbiters
package membus_arb_pkg;

    // address width for a memory of len words, never narrower than one bit
    function automatic int aw(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // index width for n requesters, never narrower than one bit
    function automatic int iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/membus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker starting at ptr
module rr_pick
    import membus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = iw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    // scan offsets from farthest to nearest so the requester closest to ptr wins
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j -= NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = PW'(j);
            end
        end
        gnt = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/membus_arbiter.sv
// membus_arbiter: round-robin sharing of one registered-read memory among NREQ requesters
module membus_arbiter
    import membus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LEN  = 256,
    parameter int DW   = 8,
    parameter int CW   = 16,
    parameter int AW   = aw(LEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] wr_in,
    input  logic [AW-1:0]   addr_in [NREQ],
    input  logic [DW-1:0]   d_in    [NREQ],
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_d,
    output logic            mem_wr,
    input  logic [DW-1:0]   mem_q,
    output logic [CW-1:0]   contention_cnt
);

    localparam int PW = iw(NREQ);

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
    } payload_t;

    payload_t        sel;
    logic            valid;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   idx;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   rd_owner_q, rd_owner_d;
    logic            rd_pend_q, rd_pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .valid(valid),
        .gnt  (pick),
        .idx  (idx)
    );

    // route the winner's payload to the memory; all strobes idle while in reset
    always_comb begin
        sel      = (rst_n && valid) ? payload_t'{wr: wr_in[idx], addr: addr_in[idx], d: d_in[idx]} : '0;
        gnt      = rst_n ? pick : '0;
        mem_wr   = sel.wr;
        mem_addr = sel.addr;
        mem_d    = sel.d;
        rvalid   = (rst_n && rd_pend_q) ? (NREQ'(1) << rd_owner_q) : '0;
        rdata    = mem_q;
        contention_cnt = cnt_q;
    end

    // next pointer, read-return owner and saturating contention count
    always_comb begin
        ptr_d      = valid ? ((idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
        rd_pend_d  = valid && !wr_in[idx];
        rd_owner_d = valid ? idx : rd_owner_q;
        cnt_d      = ($countones(req) > 1 && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // state registers; a pending read is dropped by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: randomized and directed checks against a behavioural arbiter model
module tb_membus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  wr_in = '0;
    logic [AW-1:0] addr_in [N];
    logic [DW-1:0] d_in [N];
    logic [N-1:0]  gnt, rvalid, s_gnt, s_rvalid;
    logic [DW-1:0] rdata, mem_d, mem_q, s_rdata, s_mem_d;
    logic [AW-1:0] mem_addr, s_mem_addr;
    logic          mem_wr, s_mem_wr;
    logic [15:0]   cnt16;
    logic [3:0]    cnt4;

    int vectors = 0;
    int errors = 0;

    membus_arbiter #(.NREQ(N), .LEN(256), .DW(DW), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_in(wr_in), .addr_in(addr_in), .d_in(d_in),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_d(mem_d),
        .mem_wr(mem_wr), .mem_q(mem_q), .contention_cnt(cnt16)
    );

    membus_arbiter #(.NREQ(N), .LEN(256), .DW(DW), .CW(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_in(wr_in), .addr_in(addr_in), .d_in(d_in),
        .gnt(s_gnt), .rvalid(s_rvalid), .rdata(s_rdata), .mem_addr(s_mem_addr), .mem_d(s_mem_d),
        .mem_wr(s_mem_wr), .mem_q(mem_q), .contention_cnt(cnt4)
    );

    always #5 clk = ~clk;

    // memory slave: registered read, read-before-write
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_d;
        mem_q <= mem[mem_addr];
    end

    // behavioural model: pointer, expected read return, counters, shadow memory
    int            m_ptr, m_own, m_cnt, m_cnt4, mw;
    bit            m_pend;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] mm [256];

    function automatic int winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 0; m_pend <= 0; m_own <= 0; m_cnt <= 0; m_cnt4 <= 0;
        end else begin
            mw = winner(req, m_ptr);
            m_pend <= 0;
            if (mw >= 0) begin
                m_ptr <= (mw + 1) % N;
                if (wr_in[mw]) mm[addr_in[mw]] <= d_in[mw];
                else begin
                    m_pend <= 1; m_own <= mw; m_rd <= mm[addr_in[mw]];
                end
            end
            if ($countones(req) >= 2) begin
                if (m_cnt < 65535) m_cnt <= m_cnt + 1;
                if (m_cnt4 < 15) m_cnt4 <= m_cnt4 + 1;
            end
        end
    end

    // compare every cycle mid-period against the model
    always @(negedge clk) begin
        int w;
        logic [N-1:0] eg, erv;
        logic ewr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (!rst_n) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_cnt", cnt16, 0);
        end else begin
            w = winner(req, m_ptr);
            eg = '0; ewr = 0; ea = '0; ed = '0;
            if (w >= 0) begin
                eg = N'(1) << w; ewr = wr_in[w]; ea = addr_in[w]; ed = d_in[w];
            end
            erv = m_pend ? (N'(1) << m_own) : '0;
            chk("gnt", gnt, eg);
            chk("s_gnt", s_gnt, eg);
            chk("mem_wr", mem_wr, ewr);
            chk("mem_addr", mem_addr, ea);
            chk("mem_d", mem_d, ed);
            chk("rvalid", rvalid, erv);
            chk("s_rvalid", s_rvalid, erv);
            if (m_pend) chk("rdata", rdata, m_rd);
            chk("cnt16", cnt16, m_cnt);
            chk("cnt4", cnt4, m_cnt4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; req = '0; wr_in = '0;
        tick(); tick();
        rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin addr_in[i] = '0; d_in[i] = '0; end
        for (int i = 0; i < 256; i++) begin
            mem[i] <= (i < 4) ? DW'(8'h40 + i) : '0;
            mm[i]  <= (i < 4) ? DW'(8'h40 + i) : '0;
        end
        do_reset();

        // single write then read by requester 2
        req = 4'b0100; wr_in[2] = 1; addr_in[2] = 8'h10; d_in[2] = 8'hA5;
        #1 chk("t1_gnt_wr", gnt, 4'b0100);
        tick();
        wr_in[2] = 0;
        #1 chk("t1_gnt_rd", gnt, 4'b0100);
        chk("t1_no_rvalid_wr", rvalid, 0);
        tick();
        req = '0;
        #1 chk("t1_rvalid", rvalid, 4'b0100);
        chk("t1_rdata", rdata, 8'hA5);
        tick();

        // full contention reads of preloaded words
        do_reset();
        req = 4'hF; wr_in = '0;
        for (int i = 0; i < N; i++) addr_in[i] = AW'(i);
        for (int c = 0; c < 8; c++) begin
            #1 chk("t2_gnt", gnt, 4'b0001 << (c % 4));
            chk("t2_rvalid", rvalid, c ? (4'b0001 << ((c - 1) % 4)) : 4'b0000);
            if (c > 0) chk("t2_rdata", rdata, 8'h40 + (c - 1) % 4);
            tick();
        end
        req = '0;
        #1 chk("t2_rvalid_last", rvalid, 4'b1000);
        chk("t2_rdata_last", rdata, 8'h43);
        chk("t2_cnt", cnt16, 8);
        tick();

        // pointer rotation with a late third requester
        do_reset();
        req = 4'b1001;
        for (int c = 0; c < 4; c++) begin
            #1 chk("t3_gnt", gnt, (c % 2) ? 4'b1000 : 4'b0001);
            tick();
        end
        req = 4'b1011;
        #1 chk("t3_gnt_after", gnt, 4'b0001);
        tick();
        #1 chk("t3_gnt_one", gnt, 4'b0010);
        tick();

        // write by 0 then read of same address by 1
        do_reset();
        req = 4'b0001; wr_in[0] = 1; addr_in[0] = 8'd5; d_in[0] = 8'h55;
        tick();
        req = 4'b0010; wr_in[1] = 0; addr_in[1] = 8'd5;
        tick();
        req = '0;
        #1 chk("t4_rvalid", rvalid, 4'b0010);
        chk("t4_rdata", rdata, 8'h55);
        tick();

        // asynchronous reset right after a read grant
        do_reset();
        req = 4'b0001; wr_in = 4'b0010; addr_in[0] = 8'd2;
        tick();
        req = 4'b0110; wr_in = 4'b0010;
        #1 chk("t5_rvalid_pre", rvalid, 4'b0001);
        rst_n = 0;
        #1 chk("t5_gnt", gnt, 0);
        chk("t5_rvalid", rvalid, 0);
        chk("t5_mem_wr", mem_wr, 0);
        #1 rst_n = 1;
        #1 chk("t5_first_gnt", gnt, 4'b0010);
        chk("t5_no_stray", rvalid, 0);
        tick();
        req = '0;
        #1 chk("t5_no_stray2", rvalid, 0);
        tick();

        // counter saturation on the narrow instance
        do_reset();
        req = 4'b0011; wr_in = 4'b0011;
        repeat (20) tick();
        req = '0;
        #1 chk("t6_cnt4", cnt4, 15);
        chk("t6_cnt16", cnt16, 20);
        tick();

        // randomized traffic with hold-until-granted requesters
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int w;
            w = winner(req, m_ptr);
            tick();
            for (int i = 0; i < N; i++) begin
                if (!req[i] || i == w) begin
                    req[i]     = ($urandom_range(0, 2) != 0);
                    wr_in[i]   = $urandom_range(0, 1) != 0;
                    addr_in[i] = AW'($urandom_range(0, 7));
                    d_in[i]    = DW'($urandom);
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 0;
                #1 rst_n = 1;
            end
        end
        req = '0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
